// File: rtl/stage2_pool_if.sv
// Handshake/data bundle between the stage-2 adder, the pooling stage and its consumer.
interface stage2_pool_if #(
    parameter int DATA_W = 12
);
    logic                     en;
    logic                     in_valid;
    logic signed [DATA_W-1:0] datain;
    logic signed [DATA_W-1:0] bias;
    logic signed [DATA_W-1:0] dataout;
    logic                     out_valid;
    logic                     frame_done;

    modport master (
        output en, in_valid, datain, bias,
        input  dataout, out_valid, frame_done
    );

    modport slave (
        input  en, in_valid, datain, bias,
        output dataout, out_valid, frame_done
    );
endinterface

// File: rtl/stage2_pool.sv
// Stage-2 pooling: per-pixel bias + saturate + ReLU, then 2x2 stride-2 pooling over a raster stream.
// Max pooling by default; defining STAGE2_POOL_AVG_EN selects average pooling instead.
module stage2_pool #(
    parameter int DATA_W = 12,
    parameter int MAP_W  = 10,
    parameter int MAP_H  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    stage2_pool_if.slave bus
);
    localparam int COL_W  = $clog2(MAP_W);
    localparam int ROW_W  = $clog2(MAP_H);
    localparam int HALF_W = MAP_W / 2;
    localparam int K_W    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
`ifdef STAGE2_POOL_AVG_EN
    localparam int BUF_W  = DATA_W + 1;
`else
    localparam int BUF_W  = DATA_W;
`endif
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    logic                     accept;
    logic                     colLast;
    logic                     rowLast;
    logic [K_W-1:0]           kIdx;
    logic signed [DATA_W:0]   sumExt;
    logic signed [DATA_W-1:0] pixRelu;
    logic signed [BUF_W-1:0]  pairRes;
    logic signed [BUF_W-1:0]  bufRead;
    logic signed [DATA_W-1:0] windowRes;
    logic                     bufWrite;

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] pairVal_q, pairVal_d;
    logic signed [DATA_W-1:0] dataOut_q, dataOut_d;
    logic                     outValid_q, outValid_d;
    logic                     frameDone_q, frameDone_d;
    logic signed [BUF_W-1:0]  lineBuf_q [HALF_W];

    assign accept  = bus.en && bus.in_valid;
    assign colLast = (col_q == COL_W'(MAP_W - 1));
    assign rowLast = (row_q == ROW_W'(MAP_H - 1));
    assign kIdx    = K_W'(col_q >> 1);
    assign sumExt  = {bus.datain[DATA_W-1], bus.datain} + {bus.bias[DATA_W-1], bus.bias};
    assign bufRead = lineBuf_q[kIdx];

    // Any negative sum (including negative overflow) is zeroed by ReLU, so only positive overflow saturates.
    always_comb begin
        if (sumExt[DATA_W]) begin
            pixRelu = '0;
        end else if (sumExt[DATA_W-1]) begin
            pixRelu = SAT_MAX;
        end else begin
            pixRelu = sumExt[DATA_W-1:0];
        end
    end

`ifdef STAGE2_POOL_AVG_EN
    logic signed [DATA_W+1:0] windowSum;

    assign pairRes   = {pairVal_q[DATA_W-1], pairVal_q} + {pixRelu[DATA_W-1], pixRelu};
    assign windowSum = {bufRead[BUF_W-1], bufRead} + {pairRes[BUF_W-1], pairRes};
    assign windowRes = DATA_W'(windowSum >>> 2);
`else
    assign pairRes   = (pairVal_q > pixRelu) ? pairVal_q : pixRelu;
    assign windowRes = (bufRead > pairRes) ? bufRead : pairRes;
`endif

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pairVal_d   = pairVal_q;
        dataOut_d   = dataOut_q;
        outValid_d  = 1'b0;
        frameDone_d = 1'b0;
        bufWrite    = 1'b0;
        if (accept) begin
            col_d = colLast ? '0 : col_q + 1'b1;
            if (colLast) begin
                row_d = rowLast ? '0 : row_q + 1'b1;
            end
            if (!col_q[0]) begin
                pairVal_d = pixRelu;
            end else if (!row_q[0]) begin
                bufWrite = 1'b1;
            end else begin
                outValid_d  = 1'b1;
                frameDone_d = colLast && rowLast;
                dataOut_d   = windowRes;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            pairVal_q   <= '0;
            dataOut_q   <= '0;
            outValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pairVal_q   <= pairVal_d;
            dataOut_q   <= dataOut_d;
            outValid_q  <= outValid_d;
            frameDone_q <= frameDone_d;
        end
    end

    // Even rows deposit pair results; odd rows read them back before any overwrite within a frame.
    always_ff @(posedge clk) begin
        if (rst_n && bufWrite) begin
            lineBuf_q[kIdx] <= pairRes;
        end
    end

    assign bus.dataout    = dataOut_q;
    assign bus.out_valid  = outValid_q;
    assign bus.frame_done = frameDone_q;
endmodule

// File: tb/tb_stage2_pool.sv
// Directed self-checking bench for stage2_pool (10x10 maps, 12-bit data).
// Expected window values follow STAGE2_POOL_AVG_EN when the bench is built with it.
module tb_stage2_pool;
    logic clk;
    logic rst_n;
    int   vecCount  = 0;
    int   missCount = 0;
    logic signed [11:0] lastExp = '0;

    stage2_pool_if #(.DATA_W(12)) bus ();

    stage2_pool #(
        .DATA_W(12),
        .MAP_W (10),
        .MAP_H (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic expV, input logic expF,
                               input logic signed [11:0] expD);
        vecCount++;
        assert (bus.out_valid === expV) else begin
            missCount++;
            $error("[TB] FAIL %s out_valid observed=%0b expected=%0b", tag, bus.out_valid, expV);
        end
        vecCount++;
        assert (bus.frame_done === expF) else begin
            missCount++;
            $error("[TB] FAIL %s frame_done observed=%0b expected=%0b", tag, bus.frame_done, expF);
        end
        vecCount++;
        assert (bus.dataout === expD) else begin
            missCount++;
            $error("[TB] FAIL %s dataout observed=%0d expected=%0d", tag, bus.dataout, expD);
        end
    endtask

    // Drive one cycle of inputs, then check outputs 1 time unit after the edge.
    task automatic applyStimulus(input logic e, input logic v, input logic signed [11:0] d,
                                 input logic expV, input logic expF,
                                 input logic signed [11:0] expD, input string tag);
        bus.en       = e;
        bus.in_valid = v;
        bus.datain   = d;
        @(posedge clk);
        #1;
        if (expV) lastExp = expD;
        checkOutput(tag, expV, expF, lastExp);
    endtask

    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            bus.en       = 1'b1;
            bus.in_valid = 1'b1;
            bus.datain   = 12'($urandom);
            @(posedge clk);
            #1;
            lastExp = '0;
            checkOutput("reset", 1'b0, 1'b0, 12'sd0);
        end
        rst_n = 1'b1;
    endtask

    // Max: bottom-right pixel of the window. Avg: top-left + 5, i.e. (4*t + 22) >>> 2.
    function automatic logic signed [11:0] rampExp(input int r, input int c);
`ifdef STAGE2_POOL_AVG_EN
        return 12'((r - 1) * 10 + (c - 1) + 5);
`else
        return 12'(r * 10 + c);
`endif
    endfunction

    task automatic runFrame(input bit ramp, input logic signed [11:0] pix,
                            input logic signed [11:0] expC, input bit stall,
                            input int pixLimit, input string tag);
        int n = 0;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                logic expV;
                logic signed [11:0] d;
                if (n == pixLimit) return;
                if (stall && r == 3 && c == 3)
                    repeat (4) applyStimulus(1'b0, 1'b1, 12'($urandom), 1'b0, 1'b0, 12'sd0, "stall_en");
                if (stall && r == 8 && c == 5)
                    repeat (3) applyStimulus(1'b1, 1'b0, 12'($urandom), 1'b0, 1'b0, 12'sd0, "stall_valid");
                d    = ramp ? 12'(r * 10 + c) : pix;
                expV = (r % 2 == 1) && (c % 2 == 1);
                applyStimulus(1'b1, 1'b1, d, expV, expV && r == 9 && c == 9,
                              ramp ? rampExp(r, c) : expC, tag);
                n++;
            end
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.in_valid = 1'b0;
        bus.datain   = '0;
        bus.bias     = '0;

        doReset(2);

        bus.bias = 12'sd0;
        runFrame(1'b1, 12'sd0, 12'sd0, 1'b0, 100, "ramp");

        bus.bias = 12'sd0;
        runFrame(1'b0, -12'sd5, 12'sd0, 1'b0, 100, "relu_neg");
        bus.bias = 12'sd8;
        runFrame(1'b0, -12'sd5, 12'sd3, 1'b0, 100, "relu_bias");

        bus.bias = 12'sd100;
        runFrame(1'b0, 12'sd2000, 12'sd2047, 1'b0, 100, "sat_pos");
        bus.bias = -12'sd10;
        runFrame(1'b0, -12'sd2048, 12'sd0, 1'b0, 100, "sat_neg");

        bus.bias = 12'sd0;
        runFrame(1'b1, 12'sd0, 12'sd0, 1'b1, 100, "stall");

        runFrame(1'b1, 12'sd0, 12'sd0, 1'b0, 37, "partial");
        doReset(1);
        runFrame(1'b1, 12'sd0, 12'sd0, 1'b0, 100, "b2b_first");
        runFrame(1'b1, 12'sd0, 12'sd0, 1'b0, 100, "b2b_second");

        applyStimulus(1'b1, 1'b0, 12'sd0, 1'b0, 1'b0, 12'sd0, "idle");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/stage2_pool.md
Name: stage2_pool

Overview:
Downstream neighbour of the stage-2 six-channel partial-sum adder in the LeNet-5 C3→S4 path. Consumes the adder's 12-bit signed per-pixel sum stream in raster order, one feature map at a time. For each pixel it adds a per-map bias, saturates and applies ReLU. It then performs 2x2 stride-2 max pooling and emits one pooled 12-bit value per 2x2 window, e.g. 10x10 in → 5x5 out.

Parameters:
DATA_W, 12, width of input, bias and output samples (signed)
MAP_W, 10, input feature-map width in pixels; must be even and ≥2
MAP_H, 10, input feature-map height in pixels; must be even and ≥2

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  stage enable; 0 = freeze all state
in_valid  input  1  datain carries a valid pixel this cycle
datain  input  DATA_W  signed pixel sum from the stage-2 adder
bias  input  DATA_W  signed per-map bias; held stable for the whole frame
dataout  output  DATA_W  signed pooled result (registered)
out_valid  output  1  dataout valid, one-cycle pulse per window
frame_done  output  1  one-cycle pulse coincident with the last window's out_valid

Behaviour:
- Clocking and reset: one clock (clk). rst_n is synchronous and active-low.
- Reset state: rst_n=0 at a clock edge sets dataout=0, out_valid=0, frame_done=0, col/row counters=0 and pair register=0. Line-buffer contents need no reset; they are never read before being written in the same frame.
- Accept condition: a pixel is accepted when en=1 and in_valid=1.
- en=0: counters, pair register and line buffer hold; out_valid=0 and frame_done=0; dataout holds its last value.
- en=1, in_valid=0: same hold behaviour as en=0.
- Per-pixel arithmetic: s = datain + bias, computed in DATA_W+1 bits.
  - Saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ReLU: r = (sat < 0) ? 0 : sat.
- Counters: col 0..MAP_W-1 and row 0..MAP_H-1 advance on each accepted pixel.
  - col wraps to 0 and increments row.
  - After (MAP_W-1, MAP_H-1), both counters return to 0; the next frame starts with no idle cycle.
- Pair stage:
  - Even col: pair_reg <= r.
  - Odd col: pm = max(pair_reg, r), using signed compare.
- Line buffer: MAP_W/2 entries of DATA_W bits, indexed k = col>>1.
  - Even row, odd col: buf[k] <= pm.
  - Odd row, odd col: result = max(buf[k], pm); registered into dataout with out_valid=1 on the next edge.
- Latency: out_valid asserts exactly 1 cycle after the edge accepting the bottom-right pixel of a window.
- Output count: (MAP_W/2)*(MAP_H/2) pulses per frame. out_valid is never asserted for two windows in consecutive cycles, because every window needs at least 2 accepted pixels.
- frame_done: asserted together with out_valid for window (MAP_W/2-1, MAP_H/2-1).
- Reset mid-frame: partial frame is discarded; the next accepted pixel is treated as (0,0). No output is produced for the aborted windows.
- Simultaneous rst_n=0 and accepted pixel: reset wins; the pixel is dropped.
- No backpressure: consumer must accept every out_valid pulse.

Optional Feature:
Macro STAGE2_POOL_AVG_EN.
- Defined: average pooling instead of max pooling.
  - Pair stage stores ps = pair_reg + r (DATA_W+1 bits).
  - Line buffer width becomes DATA_W+1.
  - Odd row, odd col: window sum (DATA_W+2 bits) = buf[k] + ps; result = sum >>> 2 (arithmetic shift, floor).
  - ReLU and saturation still apply per pixel, so the result always fits DATA_W.
  - Latency, counters, handshake and frame_done are unchanged.
- Undefined: max pooling as described in Behaviour.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with random datain/in_valid=1 → dataout=0, out_valid=0, frame_done=0 throughout; first post-reset pixel treated as (0,0).
2. Ramp frame: MAP_W=MAP_H=10, bias=0, pixel=row*10+col, in_valid=1 continuously → 25 pulses with values 11,13,15,17,19,31,…,99; frame_done only with 99; each pulse 1 cycle after the odd-row/odd-col pixel. With STAGE2_POOL_AVG_EN: first=5 (22>>>2), last=(88+89+98+99)>>>2=93.
3. ReLU/bias: all pixels=-5, bias=0 → 25 outputs of 0. All pixels=-5, bias=8 → 25 outputs of 3.
4. Saturation: all pixels=2000, bias=100 → 25 outputs of 2047. All pixels=-2048, bias=-10 → 25 outputs of 0.
5. Stall: ramp frame with en=0 for 4 cycles at pixel (3,3) and in_valid=0 for 3 cycles at (5,8) → identical 25-value sequence to test 2; no out_valid during stalls.
6. Mid-frame reset then back-to-back frames: rst_n=0 for 1 cycle after 37 ramp pixels, then two consecutive ramp frames → exactly 50 outputs, each frame matching test 2; two frame_done pulses.
